multdiv_issue_ctrl: RTL and testbench

- Pipeline-side controller that sits directly upstream of the multiply/divide unit.
- Accepts a MULT or DIV request from the execute stage, latches its operands and destination register, and holds the matching ctrl line high for the whole operation (the unit's outputs float unless its ctrl line is asserted).
- Stalls the pipeline while the operation is in flight.
- Returns a single-cycle writeback (result or exception code) tagged with the destination register.

---
 rtl/multdiv_issue_ctrl.sv | 160 ++++++++++++++++
 tb/tb_multdiv_issue_ctrl.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/multdiv_issue_ctrl.sv
// Issue controller in front of the multiply/divide unit: latches one MULT/DIV
// request, holds the unit's ctrl line while it runs, and returns a one-cycle writeback.
module multdiv_issue_ctrl #(
  parameter int unsigned TIMEOUT     = 64,
  parameter int unsigned EXC_RD      = 30,
  parameter int unsigned EXC_MULT    = 1,
  parameter int unsigned EXC_DIV     = 2,
  parameter int unsigned EXC_TIMEOUT = 3
) (
  input  logic        clock,
  input  logic        ctrl_reset_n,
  input  logic        flush,
  input  logic        req_valid,
  input  logic        req_op,
  input  logic [31:0] req_operandA,
  input  logic [15:0] req_operandB,
  input  logic [4:0]  req_rd,
  output logic        req_ready,
  output logic        stall,
  output logic [31:0] md_operandA,
  output logic [15:0] md_operandB,
  output logic        md_ctrl_MULT,
  output logic        md_ctrl_DIV,
  input  logic [31:0] md_result,
  input  logic        md_exception,
  input  logic        md_inputRDY,
  input  logic        md_resultRDY,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        wb_exception
);

  localparam int unsigned   CW        = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TMO_LIMIT = CW'(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_BUSY,
    S_WB
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic            r_op;
  logic [31:0]     r_a;
  logic [15:0]     r_b;
  logic [4:0]      r_rd;
  logic [31:0]     r_result;
  logic            r_exc;
  logic            r_tmo;
  logic            r_busy_first;
  logic [CW-1:0]   r_tmo_cnt;

  logic            w_active;
  logic            w_req_ready;
  logic            w_accept;
  logic            w_capture;
  logic            w_timeout;
  logic            w_wb_valid;
  logic [CW-1:0]   w_cnt_inc;

  always_comb begin
    w_active    = (r_state == S_ISSUE) || (r_state == S_BUSY);
    w_req_ready = (r_state == S_IDLE) && ctrl_reset_n && !flush;
    w_accept    = req_valid && w_req_ready;
    w_cnt_inc   = r_tmo_cnt + CW'(1);
    // The first BUSY cycle ignores resultRDY: it may still be the previous op's ready.
    w_capture   = (r_state == S_BUSY) && !r_busy_first && md_resultRDY;
    w_timeout   = w_active && (w_cnt_inc == TMO_LIMIT);
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) w_next = S_ISSUE;
      end
      S_ISSUE: begin
        if (flush)            w_next = S_IDLE;
        else if (w_timeout)   w_next = S_WB;
        else if (md_inputRDY) w_next = S_BUSY;
      end
      S_BUSY: begin
        if (flush)                       w_next = S_IDLE;
        else if (w_capture || w_timeout) w_next = S_WB;
      end
      S_WB: begin
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!ctrl_reset_n) begin
      r_state      <= S_IDLE;
      r_op         <= 1'b0;
      r_a          <= '0;
      r_b          <= '0;
      r_rd         <= '0;
      r_result     <= '0;
      r_exc        <= 1'b0;
      r_tmo        <= 1'b0;
      r_busy_first <= 1'b0;
      r_tmo_cnt    <= '0;
    end else begin
      r_state      <= w_next;
      r_busy_first <= (r_state == S_ISSUE) && (w_next == S_BUSY);
      if (w_accept) begin
        r_op      <= req_op;
        r_a       <= req_operandA;
        r_b       <= req_operandB;
        r_rd      <= req_rd;
        r_exc     <= 1'b0;
        r_tmo     <= 1'b0;
        r_tmo_cnt <= '0;
      end else if (w_active && !flush) begin
        r_tmo_cnt <= w_cnt_inc;
        // A result arriving on the timeout edge wins over the watchdog.
        if (w_capture) begin
          r_result <= md_result;
          r_exc    <= md_exception;
        end else if (w_timeout) begin
          r_tmo <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    w_wb_valid   = ctrl_reset_n && (r_state == S_WB) && !flush;
    req_ready    = w_req_ready;
    stall        = ctrl_reset_n && (w_accept || w_active);
    md_operandA  = ctrl_reset_n ? r_a : '0;
    md_operandB  = ctrl_reset_n ? r_b : '0;
    md_ctrl_MULT = ctrl_reset_n && w_active && !r_op;
    md_ctrl_DIV  = ctrl_reset_n && w_active && r_op;
    wb_valid     = w_wb_valid;
    wb_rd        = '0;
    wb_data      = '0;
    wb_exception = 1'b0;
    if (w_wb_valid) begin
      if (r_tmo) begin
        wb_rd        = 5'(EXC_RD);
        wb_data      = 32'(EXC_TIMEOUT);
        wb_exception = 1'b1;
      end else if (r_exc) begin
        wb_rd        = 5'(EXC_RD);
        wb_data      = r_op ? 32'(EXC_DIV) : 32'(EXC_MULT);
        wb_exception = 1'b1;
      end else begin
        wb_rd        = r_rd;
        wb_data      = r_result;
      end
    end
  end

endmodule

// File: tb/tb_multdiv_issue_ctrl.sv
// Directed bench for multdiv_issue_ctrl: an op-level reference model checked every
// cycle, plus literal expectations on writeback timing and contents per scenario.
module tb_multdiv_issue_ctrl;

  localparam int TIMEOUT     = 64;
  localparam int EXC_RD      = 30;
  localparam int EXC_MULT    = 1;
  localparam int EXC_DIV     = 2;
  localparam int EXC_TIMEOUT = 3;
  localparam int NEVER       = 100000;

  logic        clock = 1'b0;
  logic        ctrl_reset_n = 1'b0;
  logic        flush = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_op = 1'b0;
  logic [31:0] req_operandA = '0;
  logic [15:0] req_operandB = '0;
  logic [4:0]  req_rd = '0;
  logic        req_ready;
  logic        stall;
  logic [31:0] md_operandA;
  logic [15:0] md_operandB;
  logic        md_ctrl_MULT;
  logic        md_ctrl_DIV;
  logic [31:0] md_result = '0;
  logic        md_exception = 1'b0;
  logic        md_inputRDY = 1'b0;
  logic        md_resultRDY = 1'b0;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        wb_exception;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 0;

  multdiv_issue_ctrl #(
    .TIMEOUT(TIMEOUT), .EXC_RD(EXC_RD), .EXC_MULT(EXC_MULT),
    .EXC_DIV(EXC_DIV), .EXC_TIMEOUT(EXC_TIMEOUT)
  ) dut (
    .clock(clock), .ctrl_reset_n(ctrl_reset_n), .flush(flush),
    .req_valid(req_valid), .req_op(req_op), .req_operandA(req_operandA),
    .req_operandB(req_operandB), .req_rd(req_rd), .req_ready(req_ready),
    .stall(stall), .md_operandA(md_operandA), .md_operandB(md_operandB),
    .md_ctrl_MULT(md_ctrl_MULT), .md_ctrl_DIV(md_ctrl_DIV),
    .md_result(md_result), .md_exception(md_exception),
    .md_inputRDY(md_inputRDY), .md_resultRDY(md_resultRDY),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .wb_exception(wb_exception)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one op record, its age, whether the unit took the operands,
  // how many BUSY cycles have passed, and a pending writeback record.
  bit          m_inflight, m_issued, m_wb, m_op, m_wb_exc;
  int          m_age, m_busy_n;
  logic [31:0] m_a, m_wb_data;
  logic [15:0] m_b;
  logic [4:0]  m_rd, m_wb_rd;

  initial begin
    m_inflight = 0; m_issued = 0; m_wb = 0; m_op = 0; m_wb_exc = 0;
    m_age = 0; m_busy_n = 0; m_a = '0; m_b = '0; m_rd = '0; m_wb_rd = '0; m_wb_data = '0;
  end

  always @(posedge clock) begin
    if (!ctrl_reset_n) begin
      m_inflight <= 0; m_issued <= 0; m_wb <= 0; m_op <= 0;
      m_age <= 0; m_busy_n <= 0; m_a <= '0; m_b <= '0; m_rd <= '0;
    end else if (m_wb) begin
      m_wb <= 0;
    end else if (m_inflight) begin
      if (flush) begin
        m_inflight <= 0;
      end else if (m_issued && m_busy_n >= 1 && md_resultRDY) begin
        m_inflight <= 0;
        m_wb       <= 1;
        if (md_exception) begin
          m_wb_rd <= 5'(EXC_RD); m_wb_data <= m_op ? EXC_DIV : EXC_MULT; m_wb_exc <= 1;
        end else begin
          m_wb_rd <= m_rd; m_wb_data <= md_result; m_wb_exc <= 0;
        end
      end else if (m_age + 1 == TIMEOUT) begin
        m_inflight <= 0;
        m_wb       <= 1;
        m_wb_rd    <= 5'(EXC_RD); m_wb_data <= EXC_TIMEOUT; m_wb_exc <= 1;
      end else begin
        m_age <= m_age + 1;
        if (!m_issued) begin
          if (md_inputRDY) m_issued <= 1;
        end else begin
          m_busy_n <= m_busy_n + 1;
        end
      end
    end else if (req_valid && !flush) begin
      m_inflight <= 1; m_issued <= 0; m_age <= 0; m_busy_n <= 0;
      m_op <= req_op; m_a <= req_operandA; m_b <= req_operandB; m_rd <= req_rd;
    end
  end

  always @(negedge clock) begin
    if (chk_en) begin
      bit rst_ok, e_ready, e_wbv;
      rst_ok  = (ctrl_reset_n === 1'b1);
      e_ready = rst_ok && !m_inflight && !m_wb && !flush;
      e_wbv   = rst_ok && m_wb && !flush;
      chk("req_ready", 32'(req_ready), 32'(e_ready));
      chk("stall", 32'(stall), 32'(rst_ok && ((req_valid && e_ready) || m_inflight)));
      chk("md_ctrl_MULT", 32'(md_ctrl_MULT), 32'(rst_ok && m_inflight && !m_op));
      chk("md_ctrl_DIV", 32'(md_ctrl_DIV), 32'(rst_ok && m_inflight && m_op));
      chk("md_operandA", md_operandA, rst_ok ? m_a : 32'h0);
      chk("md_operandB", 32'(md_operandB), rst_ok ? 32'(m_b) : 32'h0);
      chk("wb_valid", 32'(wb_valid), 32'(e_wbv));
      chk("wb_rd", 32'(wb_rd), e_wbv ? 32'(m_wb_rd) : 32'h0);
      chk("wb_data", wb_data, e_wbv ? m_wb_data : 32'h0);
      chk("wb_exception", 32'(wb_exception), 32'(e_wbv && m_wb_exc));
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Cycle k=0 presents the request; the unit's handshakes are scheduled by cycle index.
  task automatic drive_op(input logic op, input logic [31:0] a, input logic [15:0] b,
                          input logic [4:0] rd, input int rdy_k, input int res_k,
                          input int stale_len, input logic [31:0] res, input logic exc,
                          input int flush_k, input int ncyc, output int wb_k,
                          output logic [4:0] o_rd, output logic [31:0] o_data,
                          output logic o_exc);
    wb_k = -1; o_rd = '0; o_data = '0; o_exc = 1'b0;
    for (int k = 0; k < ncyc; k++) begin
      req_valid    = (k == 0);
      req_op       = op;
      req_operandA = a;
      req_operandB = b;
      req_rd       = rd;
      flush        = (k == flush_k);
      md_inputRDY  = (k == rdy_k);
      if (k == res_k) begin
        md_resultRDY = 1'b1; md_result = res; md_exception = exc;
      end else if (k < stale_len) begin
        md_resultRDY = 1'b1; md_result = 32'hDEAD_BEEF; md_exception = 1'b0;
      end else begin
        md_resultRDY = 1'b0; md_result = '0; md_exception = 1'b0;
      end
      @(negedge clock);
      if (wb_valid === 1'b1 && wb_k < 0) begin
        wb_k = k; o_rd = wb_rd; o_data = wb_data; o_exc = wb_exception;
      end
      step();
    end
    req_valid = 0; flush = 0; md_inputRDY = 0; md_resultRDY = 0;
    md_result = '0; md_exception = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "bench watchdog");
  end

  initial begin
    int          wk;
    logic [4:0]  rrd;
    logic [31:0] rdata;
    logic        rexc;

    // Reset
    @(negedge clock);
    chk("reset_stall", 32'(stall), 32'h0);
    chk("reset_wb_valid", 32'(wb_valid), 32'h0);
    step(); step();
    chk_en = 1;
    ctrl_reset_n = 1'b1;
    step();

    // 1: MULT 7*6, result 10 cycles after ISSUE
    drive_op(1'b0, 32'd7, 16'd6, 5'd5, 1, 11, 0, 32'd42, 1'b0, NEVER, 16, wk, rrd, rdata, rexc);
    chk("t1_wb_cycle", 32'(wk), 32'd12);
    chk("t1_wb_rd", 32'(rrd), 32'd5);
    chk("t1_wb_data", rdata, 32'd42);
    chk("t1_wb_exc", 32'(rexc), 32'd0);
    @(negedge clock);
    chk("t1_ready_after", 32'(req_ready), 32'd1);
    step();

    // Minimum latency, rd=0 still writes back
    drive_op(1'b0, 32'd9, 16'd11, 5'd0, 1, 3, 0, 32'd99, 1'b0, NEVER, 6, wk, rrd, rdata, rexc);
    chk("min_wb_cycle", 32'(wk), 32'd4);
    chk("min_wb_rd", 32'(rrd), 32'd0);
    chk("min_wb_data", rdata, 32'd99);

    // 2: DIV by zero raises a unit exception
    drive_op(1'b1, 32'd100, 16'd0, 5'd7, 1, 4, 0, 32'h0, 1'b1, NEVER, 8, wk, rrd, rdata, rexc);
    chk("t2_wb_cycle", 32'(wk), 32'd5);
    chk("t2_wb_rd", 32'(rrd), 32'd30);
    chk("t2_wb_data", rdata, 32'd2);
    chk("t2_wb_exc", 32'(rexc), 32'd1);

    // 3: watchdog timeout
    drive_op(1'b0, 32'd5, 16'd5, 5'd8, 1, NEVER, 0, 32'h0, 1'b0, NEVER, 70, wk, rrd, rdata, rexc);
    chk("t3_wb_cycle", 32'(wk), 32'd65);
    chk("t3_wb_rd", 32'(rrd), 32'd30);
    chk("t3_wb_data", rdata, 32'd3);
    chk("t3_wb_exc", 32'(rexc), 32'd1);

    // 4a: flush in the 3rd BUSY cycle
    drive_op(1'b0, 32'd2, 16'd3, 5'd4, 1, 10, 0, 32'd6, 1'b0, 4, 14, wk, rrd, rdata, rexc);
    chk("t4a_no_wb", 32'(wk), 32'hFFFF_FFFF);
    // 4b: flush lands on the WB cycle
    drive_op(1'b0, 32'd2, 16'd3, 5'd4, 1, 3, 0, 32'd6, 1'b0, 4, 7, wk, rrd, rdata, rexc);
    chk("t4b_no_wb", 32'(wk), 32'hFFFF_FFFF);

    // 5: reset mid-BUSY with a request held during reset
    drive_op(1'b0, 32'hAAAA_0001, 16'h5555, 5'd3, 1, NEVER, 0, 32'h0, 1'b0, NEVER, 4, wk, rrd, rdata, rexc);
    ctrl_reset_n = 1'b0;
    req_valid = 1'b1; req_op = 1'b0; req_operandA = 32'd77; req_operandB = 16'd1; req_rd = 5'd2;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk("t5_rst_ready", 32'(req_ready), 32'h0);
      chk("t5_rst_stall", 32'(stall), 32'h0);
      chk("t5_rst_ctrl", 32'({md_ctrl_MULT, md_ctrl_DIV}), 32'h0);
      chk("t5_rst_opA", md_operandA, 32'h0);
      step();
    end
    ctrl_reset_n = 1'b1;
    req_valid = 1'b0;
    @(negedge clock);
    chk("t5_post_opA", md_operandA, 32'h0);
    chk("t5_post_stall", 32'(stall), 32'h0);
    step();
    drive_op(1'b0, 32'd3, 16'd4, 5'd9, 1, 3, 0, 32'd12, 1'b0, NEVER, 6, wk, rrd, rdata, rexc);
    chk("t5_wb_cycle", 32'(wk), 32'd4);
    chk("t5_wb_rd", 32'(rrd), 32'd9);
    chk("t5_wb_data", rdata, 32'd12);

    // 6: stale resultRDY through the first BUSY cycle, real result 5 cycles later
    drive_op(1'b0, 32'd7, 16'd11, 5'd6, 1, 7, 3, 32'd77, 1'b0, NEVER, 10, wk, rrd, rdata, rexc);
    chk("t6_wb_cycle", 32'(wk), 32'd8);
    chk("t6_wb_data", rdata, 32'd77);

    // Request with flush is refused
    req_valid = 1'b1; flush = 1'b1;
    @(negedge clock);
    chk("flush_req_ready", 32'(req_ready), 32'h0);
    chk("flush_req_stall", 32'(stall), 32'h0);
    step();
    req_valid = 1'b0; flush = 1'b0;
    @(negedge clock);
    chk("flush_req_not_taken", 32'(stall | md_ctrl_MULT | md_ctrl_DIV), 32'h0);
    step();

    chk_en = 0;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
